// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined RISC-V immediate encoder (inverse of the
// immediate extractor). It scatters a 32-bit immediate into instruction
// bits [31:7]. Non-immediate bits come from a template.
// Optional feature macro: IMM_ENC_SELFCHECK_EN enables a round-trip
// decode check that drives the sticky o_mismatch flag.
module imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_imm_ctl,
  input  logic [31:0]      i_imm,
  input  logic [24:0]      i_template,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [24:0]      o_instr_bits,
  output logic [1:0]       o_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_mismatch
);

  localparam logic [1:0]       FMT_I   = 2'b00;
  localparam logic [1:0]       FMT_S   = 2'b01;
  localparam logic [1:0]       FMT_B   = 2'b10;
  localparam logic [1:0]       FMT_J   = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Immediate does not sign-fit the selected format.
  function automatic logic range_err(input logic [1:0] ctl, input logic [31:0] imm);
    logic r;
    case (ctl)
      FMT_I, FMT_S: r = !((&imm[31:11]) || (~|imm[31:11]));
      FMT_B:        r = !((&imm[31:12]) || (~|imm[31:12]));
      FMT_J:        r = !((&imm[31:20]) || (~|imm[31:20]));
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

  // Branch and jump offsets must be halfword aligned.
  function automatic logic align_err(input logic [1:0] ctl, input logic [31:0] imm);
    return ctl[1] & imm[0];
  endfunction

  // Scatter the immediate into bits [31:7]; untouched fields keep the template.
  function automatic logic [24:0] pack_imm(input logic [1:0] ctl, input logic [31:0] imm,
                                           input logic [24:0] tmpl);
    logic [24:0] b;
    case (ctl)
      FMT_I:   b = {imm[11:0], tmpl[12:0]};
      FMT_S:   b = {imm[11:5], tmpl[17:5], imm[4:0]};
      FMT_B:   b = {imm[12], imm[10:5], tmpl[17:5], imm[4:1], imm[11]};
      FMT_J:   b = {imm[20], imm[10:1], imm[11], imm[19:12], tmpl[4:0]};
      default: b = tmpl;
    endcase
    return b;
  endfunction

`ifdef IMM_ENC_SELFCHECK_EN
  // Standard extraction: rebuild the sign-extended immediate from bits [31:7].
  function automatic logic [31:0] unpack_imm(input logic [1:0] ctl, input logic [24:0] b);
    logic [31:0] v;
    case (ctl)
      FMT_I:   v = {{20{b[24]}}, b[24:13]};
      FMT_S:   v = {{20{b[24]}}, b[24:18], b[4:0]};
      FMT_B:   v = {{19{b[24]}}, b[24], b[0], b[23:18], b[4:1], 1'b0};
      FMT_J:   v = {{11{b[24]}}, b[24], b[12:5], b[13], b[23:14], 1'b0};
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction
`endif

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_ctl_q,   s1_ctl_d;
  logic [31:0]      s1_imm_q,   s1_imm_d;
  logic [24:0]      s1_tmpl_q,  s1_tmpl_d;
  logic [1:0]       s1_err_q,   s1_err_d;
  logic             s2_valid_q, s2_valid_d;
  logic [24:0]      s2_bits_q,  s2_bits_d;
  logic [1:0]       s2_err_q,   s2_err_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             mis_q,      mis_d;
`ifdef IMM_ENC_SELFCHECK_EN
  logic [1:0]       s2_ctl_q,   s2_ctl_d;
  logic [31:0]      s2_imm_q,   s2_imm_d;
`endif
  logic             s2_adv_s;
  logic             in_fire_s;
  logic             out_fire_s;

  // Handshakes: o_ready looks through S2 so a full pipe keeps streaming.
  always_comb begin
    s2_adv_s   = !s2_valid_q || i_ready;
    o_ready    = !s1_valid_q || s2_adv_s;
    in_fire_s  = i_valid && o_ready;
    out_fire_s = s2_valid_q && i_ready;
  end

  // Next-state for both stages, the error counter and the mismatch flag.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ctl_d   = s1_ctl_q;
    s1_imm_d   = s1_imm_q;
    s1_tmpl_d  = s1_tmpl_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_bits_d  = s2_bits_q;
    s2_err_d   = s2_err_q;
    cnt_d      = cnt_q;
    mis_d      = mis_q;
`ifdef IMM_ENC_SELFCHECK_EN
    s2_ctl_d   = s2_ctl_q;
    s2_imm_d   = s2_imm_q;
`endif
    if (o_ready) begin
      s1_valid_d = i_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (in_fire_s) begin
      s1_ctl_d  = i_imm_ctl;
      s1_imm_d  = i_imm;
      s1_tmpl_d = i_template;
      s1_err_d  = {range_err(i_imm_ctl, i_imm), align_err(i_imm_ctl, i_imm)};
    end else begin
      s1_ctl_d  = s1_ctl_q;
    end
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (s2_adv_s && s1_valid_q) begin
      s2_bits_d = pack_imm(s1_ctl_q, s1_imm_q, s1_tmpl_q);
      s2_err_d  = s1_err_q;
`ifdef IMM_ENC_SELFCHECK_EN
      s2_ctl_d  = s1_ctl_q;
      s2_imm_d  = s1_imm_q;
`endif
    end else begin
      s2_bits_d = s2_bits_q;
    end
    if (out_fire_s && (s2_err_q != 2'b00) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
`ifdef IMM_ENC_SELFCHECK_EN
    if (out_fire_s && (s2_err_q == 2'b00) && (unpack_imm(s2_ctl_q, s2_bits_q) != s2_imm_q)) begin
      mis_d = 1'b1;
    end else begin
      mis_d = mis_q;
    end
`else
    mis_d = 1'b0;
`endif
  end

  // State registers; reset empties the pipe and clears the status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ctl_q   <= 2'b00;
      s1_imm_q   <= 32'h0000_0000;
      s1_tmpl_q  <= 25'h000_0000;
      s1_err_q   <= 2'b00;
      s2_valid_q <= 1'b0;
      s2_bits_q  <= 25'h000_0000;
      s2_err_q   <= 2'b00;
      cnt_q      <= {CNT_W{1'b0}};
      mis_q      <= 1'b0;
`ifdef IMM_ENC_SELFCHECK_EN
      s2_ctl_q   <= 2'b00;
      s2_imm_q   <= 32'h0000_0000;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ctl_q   <= s1_ctl_d;
      s1_imm_q   <= s1_imm_d;
      s1_tmpl_q  <= s1_tmpl_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_bits_q  <= s2_bits_d;
      s2_err_q   <= s2_err_d;
      cnt_q      <= cnt_d;
      mis_q      <= mis_d;
`ifdef IMM_ENC_SELFCHECK_EN
      s2_ctl_q   <= s2_ctl_d;
      s2_imm_q   <= s2_imm_d;
`endif
    end
  end

  assign o_valid      = s2_valid_q;
  assign o_instr_bits = s2_bits_q;
  assign o_err        = s2_err_q;
  assign o_err_cnt    = cnt_q;
  assign o_mismatch   = mis_q;

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined immediate encoder for the RISC-V data path: the inverse of the immediate extractor. It takes a 32-bit immediate and an immediate-format select, and scatters the immediate into instruction bits [31:7]. Any non-immediate field bits (rd, rs1, rs2, funct3) are merged from a template. It is used by the instruction-patching/assembler path and by self-test benches. Range and alignment errors are flagged, not trapped.

## Interface
Parameters:
- CNT_W, 8, width of the saturating error counter

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input request valid
- o_ready  out  1  encoder can accept this cycle
- i_imm_ctl  in  2  format select: 00 I, 01 S, 10 B, 11 J
- i_imm  in  32  signed immediate, byte offset for B/J
- i_template  in  25  instruction bits [31:7]; non-immediate bits pass through
- o_valid  out  1  output valid
- i_ready  in  1  downstream accepts
- o_instr_bits  out  25  encoded instruction bits [31:7] (bit n = instr[n+7])
- o_err  out  2  [1] range error, [0] alignment error
- o_err_cnt  out  CNT_W  count of outputs delivered with o_err != 0, saturating
- o_mismatch  out  1  sticky round-trip self-check failure (see Configuration)

## Operation
- Two stages, S1 and S2, each with a valid bit.
- S1 registers the inputs and the range/alignment flags. S2 registers the packed result.
- Bit placement, by field index in o_instr_bits:
  - I: [24:13]=imm[11:0]; [12:0] from template.
  - S: [24:18]=imm[11:5], [4:0]=imm[4:0]; [17:5] from template.
  - B: [24]=imm[12], [23:18]=imm[10:5], [4:1]=imm[4:1], [0]=imm[11]; [17:5] from template.
  - J: [24]=imm[20], [23:14]=imm[10:1], [13]=imm[11], [12:5]=imm[19:12]; [4:0] from template.
- Range error: imm does not sign-fit the format.
  - I and S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal.
  - J: imm[31:20] not all equal.
- Alignment error: B or J with imm[0]=1. I and S never raise it.
- On error the result is still produced, with truncated bits. The error is not a stall condition.
- o_err_cnt increments on each output handshake (o_valid && i_ready) with o_err != 0. It holds at 2^CNT_W-1.

## Timing
- Reset (async assert, sync deassert assumed from the reset tree) sets:
  - S1/S2 valid = 0, o_valid = 0
  - o_instr_bits = 0, o_err = 0
  - o_err_cnt = 0, o_mismatch = 0
- Latency: 2 cycles. An input accepted at edge N is presented at o_valid after edge N+1.
- Handshakes:
  - Input transfer on i_valid && o_ready. Output transfer on o_valid && i_ready.
  - s2_adv = !s2_valid || i_ready.
  - o_ready = !s1_valid || s2_adv. This is combinational from i_ready and has no registered bubble.
- Full throughput: 1 item/cycle while i_ready=1.
- Backpressure:
  - With i_ready=0, at most 2 items are held (S1 and S2) and o_ready drops.
  - o_instr_bits, o_err and o_valid stay stable until the output transfers.
- Simultaneous input accept and output transfer in a full pipe is legal, with no loss or duplication.
- Reset mid-operation drops all in-flight items. There is no partial output.
- Counter increment and the sticky mismatch bit update only on the output-transfer edge.

## Configuration
- Macro `IMM_ENC_SELFCHECK_EN`.
- Defined:
  - S2 also decodes o_instr_bits back to 32 bits using the standard extraction rules for i_imm_ctl. The decode is sign-extended and the B/J LSB is 0.
  - The decode is compared against the S1 immediate.
  - On an output transfer with o_err=0 and a mismatch, o_mismatch sets and stays set until reset.
- Undefined: o_mismatch is tied to 0 and no decode logic is built. The port remains in both builds.

## Test plan
- I, imm=0xFFFFFFFF, template=0x0001FFF -> o_instr_bits=0x1FFFFFF, o_err=00, o_valid two edges after accept.
- B, imm=0xFFFFF000, template=0 -> o_instr_bits=0x1000000, o_err=00. B, imm=0x00000003 -> o_err=01, o_err_cnt increments by 1.
- J, imm=0x00100000 -> o_err=10. J, imm=0x000FFFFE -> o_instr_bits=0x0FFFFE0, o_err=00.
- Backpressure:
  - Stimulus: stream 4 S-type items with i_ready=0 for 3 cycles.
  - Required: o_ready=0 once 2 items are held and o_instr_bits is stable.
  - On release: all 4 items are delivered in order, none duplicated.
- Force 300 errored outputs with CNT_W=8 -> o_err_cnt saturates at 255. Assert i_rst_n=0 mid-stream -> o_valid=0 and o_err_cnt=0 immediately.
- With `IMM_ENC_SELFCHECK_EN`, random legal immediates in all four formats for 10k items -> o_mismatch stays 0.
